// File: rtl/audio_mixer_seq.sv
// Time-multiplexed stereo mixer: one multiply-accumulate slot per clock, NCH channels
// with per-channel volume/pan, saturated OW-bit outputs, CPU index/data register port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for tick; accumulators hold the last frame's sums
// ACCUM | one channel per cycle is scaled and added to accL/accR
// DONE  | outputs hold the new frame, sample_stb high; tick here starts the next frame
module audio_mixer_seq #(
    parameter int             NCH         = 10,
    parameter int             IW          = 8,
    parameter int             OW          = 12,
    parameter int             HEADROOM    = 2,
    parameter logic [NCH-1:0] SIGNED_MASK = '0,
    parameter logic [7:0]     IDX_PORT    = 8'hF6,
    parameter logic [7:0]     DATA_PORT   = 8'hF7
) (
    input  logic                   clk,
    input  logic                   mrst_n,
    input  logic [7:0]             a,
    input  logic                   iorq_n,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   oe,
    input  logic [NCH*IW-1:0]      ch_in,
    input  logic                   tick,
    output logic signed [OW-1:0]   out_left,
    output logic signed [OW-1:0]   out_right,
    output logic                   sample_stb,
    output logic                   busy
);

    localparam int CW = $clog2(NCH);
    localparam int PW = IW + 6;
    localparam int AW = PW + $clog2(NCH);
    localparam int SH = IW + 4 - OW + HEADROOM;
    localparam int SW = ((AW > OW) ? AW : OW) + 1;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         ch;
    logic signed [AW-1:0]  acc_l, acc_r;
    logic signed [AW-1:0]  acc_l_nxt, acc_r_nxt;
    logic [7:0]            idx;
    logic [5:0]            cfg [NCH];
    logic                  overrun, clip_l, clip_r;

    logic                  wr_cyc, rd_cyc, idx_wr, data_wr;
    logic                  idx_is_ch, idx_is_status, status_clr;
    logic [CW-1:0]         idx_ch;
    logic [7:0]            rd_data;
    logic                  unused_din;

    logic [IW-1:0]         raw;
    logic [5:0]            cur_cfg;
    logic signed [IW:0]    s;
    logic [4:0]            g;
    logic signed [PW-1:0]  s_w, g_w, p;
    logic signed [AW-1:0]  p_ext;
    logic [OW:0]           sat_l, sat_r;
    logic                  last_slot, tick_take;

    // Returns {clip, value}: floor shift, then clamp to the signed OW-bit range.
    function automatic logic [OW:0] saturate(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] sh;
        logic signed [SW-1:0] w;
        sh = v >>> SH;
        w  = {{(SW-AW){sh[AW-1]}}, sh};
        if (w > SAT_MAX)
            saturate = {1'b1, SAT_MAX[OW-1:0]};
        else if (w < SAT_MIN)
            saturate = {1'b1, SAT_MIN[OW-1:0]};
        else
            saturate = {1'b0, w[OW-1:0]};
    endfunction

    assign wr_cyc        = !iorq_n && !wr_n;
    assign rd_cyc        = !iorq_n && !rd_n;
    assign idx_wr        = wr_cyc && (a == IDX_PORT);
    assign data_wr       = wr_cyc && (a == DATA_PORT);
    assign idx_is_ch     = 32'(idx) < NCH;
    assign idx_is_status = idx == 8'hFF;
    assign idx_ch        = idx[CW-1:0];
    assign status_clr    = data_wr && idx_is_status;
    assign unused_din    = ^din[5:4];

    always_comb begin
        rd_data = 8'h00;
        if (idx_is_ch)
            rd_data = {cfg[idx_ch][5:4], 2'b00, cfg[idx_ch][3:0]};
        else if (idx_is_status)
            rd_data = {5'b00000, clip_r, clip_l, overrun};
    end

    always_comb begin
        oe   = rd_cyc && ((a == IDX_PORT) || (a == DATA_PORT));
        dout = 8'h00;
        if (oe)
            dout = (a == IDX_PORT) ? idx : rd_data;
    end

    // Unsigned channels are excess-2^(IW-1): flipping the MSB recentres them on zero.
    always_comb begin
        raw     = ch_in[ch*IW +: IW];
        cur_cfg = cfg[ch];
        if (SIGNED_MASK[ch])
            s = {raw[IW-1], raw};
        else
            s = {~raw[IW-1], ~raw[IW-1], raw[IW-2:0]};
        g         = {1'b0, cur_cfg[3:0]} + 5'd1;
        s_w       = {{(PW-IW-1){s[IW]}}, s};
        g_w       = {{(PW-5){1'b0}}, g};
        p         = s_w * g_w;
        p_ext     = {{(AW-PW){p[PW-1]}}, p};
        acc_l_nxt = acc_l + (cur_cfg[5] ? p_ext : '0);
        acc_r_nxt = acc_r + (cur_cfg[4] ? p_ext : '0);
        sat_l     = saturate(acc_l_nxt);
        sat_r     = saturate(acc_r_nxt);
    end

    assign last_slot = (state == ACCUM) && (ch == CW'(NCH - 1));
    assign tick_take = tick && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        sample_stb = 1'b0;
        case (state)
            IDLE: begin
                if (tick)
                    state_nxt = ACCUM;
            end
            ACCUM: begin
                busy = 1'b1;
                if (ch == CW'(NCH - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                sample_stb = 1'b1;
                state_nxt  = tick ? ACCUM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            idx <= 8'h00;
            for (int k = 0; k < NCH; k++)
                cfg[k] <= 6'b11_1111;
        end else begin
            if (idx_wr)
                idx <= din;
            if (data_wr && idx_is_ch)
                cfg[idx_ch] <= {din[7:6], din[3:0]};
        end
    end

    // Outputs load on the final slot so they are already valid while sample_stb is high.
    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            ch        <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            out_left  <= '0;
            out_right <= '0;
            overrun   <= 1'b0;
            clip_l    <= 1'b0;
            clip_r    <= 1'b0;
        end else begin
            if (tick_take) begin
                ch    <= '0;
                acc_l <= '0;
                acc_r <= '0;
            end else if (state == ACCUM) begin
                acc_l <= acc_l_nxt;
                acc_r <= acc_r_nxt;
                if (!last_slot)
                    ch <= ch + CW'(1);
            end
            if (last_slot) begin
                out_left  <= sat_l[OW-1:0];
                out_right <= sat_r[OW-1:0];
            end
            overrun <= (overrun && !status_clr) || (tick && (state == ACCUM));
            clip_l  <= (clip_l && !status_clr) || (last_slot && sat_l[OW]);
            clip_r  <= (clip_r && !status_clr) || (last_slot && sat_r[OW]);
        end
    end

endmodule
